wb_dma_fetch: RTL and testbench
===============================

// Module: wb_dma_fetch
// PURPOSE
//  Wishbone read initiator feeding a word FIFO from a circular SDRAM region (video/sound DMA).
//  Issues single and 2-beat incrementing bursts (cti=010) to the SDRAM controller slave.
//  Consumers pop 32-bit words from a show-ahead FIFO. Read-only: never writes memory.
// PARAMETERS
//  FIFO_AW   4   log2 FIFO depth in 32-bit words (depth 16)
// PORTS
//  wb_clk      in   1   single clock for all logic
//  wb_rst      in   1   synchronous reset, active high
//  enable      in   1   level; 1 = fetch continuously, 0 = stop and flush
//  start_adr   in   22  region first word address (byte adr [23:2])
//  end_adr     in   22  region last word address, inclusive
//  busy        out  1   1 while a Wishbone cycle is in progress
//  level       out  FIFO_AW+1  FIFO occupancy in words
//  rd_en       in   1   pop request
//  rd_dat      out  32  head word, valid when rd_empty=0
//  rd_empty    out  1   FIFO empty
//  underrun    out  1   sticky: rd_en while empty
//  wb_adr      out  24  byte address, [1:0]=00
//  wb_dat_i    in   32  read data from slave
//  wb_ack      in   1   beat acknowledge
//  wb_cyc      out  1   cycle
//  wb_stb      out  1   strobe
//  wb_we       out  1   constant 0
//  wb_sel      out  4   constant 4'hF
//  wb_cti      out  3   000 single, 010 burst beat 1, 111 burst last beat
// BEHAVIOUR
//  Reset: wb_cyc=wb_stb=0, wb_cti=000, wb_adr=0, busy=0, level=0, rd_empty=1, underrun=0,
//   fetch pointer=start_adr, FSM=IDLE. Reset mid-cycle drops cyc/stb at the next edge; ack then ignored.
//  FSM IDLE->REQ when enable=1 and free=(DEPTH-level)>=2; cyc/stb/adr/cti registered on that edge.
//   Burst if ptr[0]==0 (wb_adr[2]=0) and ptr!=end_adr: cti=010, else cti=000.
//  REQ: hold cyc/stb/adr/cti stable until wb_ack. On ack: push wb_dat_i, advance ptr.
//   Single -> GAP. Burst -> BURST2: next edge adr=ptr (+4 bytes), cti=111, cyc/stb held.
//  BURST2: hold until wb_ack; push word, advance ptr -> GAP. Acks on consecutive clocks accepted.
//  GAP: cyc=stb=0 exactly one cycle (slave must see strobe drop) -> IDLE.
//  Pointer advance: ptr <= (ptr==end_adr) ? start_adr : ptr+1. end_adr<start_adr: advance
//   is ptr+1 mod 2^22 until ptr==end_adr. start/end sampled only at advance and at enable 0->1.
//  enable 0->1 while IDLE: ptr<=start_adr, underrun<=0.
//  enable=0: no new cycle; an open cycle completes all beats (data discarded), then FIFO flushed
//   (level=0) in GAP; while IDLE and enable=0 FIFO held flushed.
//  FIFO: show-ahead; rd_dat = head combinationally from storage. Push+pop same cycle: level unchanged.
//   rd_en with rd_empty=1: no pop, underrun<=1 (sticky). Overflow impossible: cycle starts
//   only with free>=2 and at most 2 beats outstanding; push while full is a design error (assert).
//  busy=1 in REQ and BURST2 only. wb_ack outside REQ/BURST2 ignored.
//  Throughput: one word per ack; 1 gap cycle between Wishbone cycles.
// TESTING
//  1 Reset, enable=1, start=0x100,end=0x107, slave acks 3 clk later -> adrs 0x400(010),0x404(111),
//    0x408(010)...; GAP of 1 clk between cycles; FIFO data in address order.
//  2 start=0x101 (odd) -> first cycle single cti=000 adr 0x404, then burst from 0x408.
//  3 end=0x102, start=0x100 -> 0x400/0x404 burst, 0x408 single (ptr==end), then wraps to 0x400.
//  4 No pops, fill to level=15 -> no new cycle (free<2); pop 1 -> level 14, burst issued.
//  5 rd_en with empty after reset -> underrun=1, level stays 0; enable 0->1 clears underrun.
//  6 enable=0 between beat 1 ack and beat 2 -> beat 2 completed, then level=0, cyc=0, busy=0;
//    wb_rst in REQ -> next clk cyc=stb=0, level=0.

Source files
------------

// File: rtl/wb_dma_fetch_if.sv
// Wishbone read-initiator bus bundle between the DMA fetcher (master)
// and the SDRAM controller (slave).
interface wb_dma_fetch_if;
  logic [23:0] adr;
  logic [31:0] dat_i;
  logic        ack;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;

  modport master (output adr, cyc, stb, we, sel, cti, input dat_i, ack);
  modport slave  (input adr, cyc, stb, we, sel, cti, output dat_i, ack);
endinterface

// File: rtl/wb_dma_fetch.sv
// Wishbone read initiator that streams a circular SDRAM word region into a
// show-ahead FIFO using single reads and 2-beat incrementing bursts.
module wb_dma_fetch #(
  parameter int FIFO_AW = 4
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic               enable,
  input  logic [21:0]        start_adr,
  input  logic [21:0]        end_adr,
  output logic               busy,
  output logic [FIFO_AW:0]   level,
  input  logic               rd_en,
  output logic [31:0]        rd_dat,
  output logic               rd_empty,
  output logic               underrun,
  wb_dma_fetch_if.master     wb
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL       = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] LAUNCH_MAX = (FIFO_AW+1)'(DEPTH - 2);
  localparam logic [2:0] CTI_SINGLE = 3'b000;
  localparam logic [2:0] CTI_BURST  = 3'b010;
  localparam logic [2:0] CTI_LAST   = 3'b111;

  typedef enum logic [1:0] {IDLE, REQ, BURST2, GAP} state_e;

  state_e              state_q, state_d;
  logic [21:0]         ptr_q, ptr_d;
  logic [21:0]         adr_q, adr_d;
  logic [2:0]          cti_q, cti_d;
  logic                cyc_q, cyc_d;
  logic                underrun_q, underrun_d;
  logic                enable_q;
  logic [FIFO_AW:0]    level_q, level_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]         fifo_mem [DEPTH];

  logic [21:0] ptr_next;
  logic [21:0] launch_ptr;
  logic        ack_ok, push, pop, flush, rise, launch, free_ok;

  assign ptr_next   = (ptr_q == end_adr) ? start_adr : ptr_q + 22'd1;
  assign rise       = enable && !enable_q && (state_q == IDLE);
  assign launch_ptr = rise ? start_adr : ptr_q;
  assign free_ok    = (level_q <= LAUNCH_MAX);
  assign ack_ok     = wb.ack && ((state_q == REQ) || (state_q == BURST2));
  // Beats that complete while disabled are still taken from the bus but dropped.
  assign push       = ack_ok && enable;
  assign pop        = rd_en && !rd_empty;
  assign flush      = !enable && ((state_q == IDLE) || (state_q == GAP));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    adr_d      = adr_q;
    cti_d      = cti_q;
    cyc_d      = cyc_q;
    underrun_d = underrun_q;
    launch     = 1'b0;

    if (rd_en && rd_empty) underrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (rise) begin
          ptr_d      = start_adr;
          underrun_d = 1'b0;
        end
        launch = enable && free_ok;
      end
      REQ: begin
        if (ack_ok) begin
          ptr_d = ptr_next;
          if (cti_q == CTI_BURST) begin
            state_d = BURST2;
            adr_d   = ptr_next;
            cti_d   = CTI_LAST;
          end else begin
            state_d = GAP;
            cyc_d   = 1'b0;
          end
        end
      end
      BURST2: begin
        if (ack_ok) begin
          ptr_d   = ptr_next;
          state_d = GAP;
          cyc_d   = 1'b0;
        end
      end
      GAP: begin
        // Strobe has been low for this cycle, so the next request may start now.
        state_d = IDLE;
        launch  = enable && free_ok;
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d = REQ;
      cyc_d   = 1'b1;
      adr_d   = launch_ptr;
      cti_d   = (!launch_ptr[0] && (launch_ptr != end_adr)) ? CTI_BURST : CTI_SINGLE;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q    <= IDLE;
      ptr_q      <= start_adr;
      adr_q      <= '0;
      cti_q      <= CTI_SINGLE;
      cyc_q      <= 1'b0;
      underrun_q <= 1'b0;
      enable_q   <= 1'b0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      adr_q      <= adr_d;
      cti_q      <= cti_d;
      cyc_q      <= cyc_d;
      underrun_q <= underrun_d;
      enable_q   <= enable;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= wb.dat_i;
  end

  assert property (@(posedge wb_clk) disable iff (wb_rst) !(push && (level_q == FULL)));

  assign wb.adr   = {adr_q, 2'b00};
  assign wb.cyc   = cyc_q;
  assign wb.stb   = cyc_q;
  assign wb.we    = 1'b0;
  assign wb.sel   = 4'hF;
  assign wb.cti   = cti_q;

  assign busy     = (state_q == REQ) || (state_q == BURST2);
  assign level    = level_q;
  assign rd_dat   = fifo_mem[rd_ptr_q];
  assign rd_empty = (level_q == '0);
  assign underrun = underrun_q;

endmodule

// File: tb/tb_wb_dma_fetch.sv
// Directed phases with randomized slave latency and pops, checked every
// cycle against a transaction-level model of the fetcher and its FIFO.
module tb_wb_dma_fetch;

  localparam int DEPTH = 16;

  logic        wb_clk;
  logic        wb_rst;
  logic        enable;
  logic [21:0] start_adr;
  logic [21:0] end_adr;
  logic        busy;
  logic [4:0]  level;
  logic        rd_en;
  logic [31:0] rd_dat;
  logic        rd_empty;
  logic        underrun;

  wb_dma_fetch_if wb ();

  wb_dma_fetch #(.FIFO_AW(4)) dut (
    .wb_clk    (wb_clk),
    .wb_rst    (wb_rst),
    .enable    (enable),
    .start_adr (start_adr),
    .end_adr   (end_adr),
    .busy      (busy),
    .level     (level),
    .rd_en     (rd_en),
    .rd_dat    (rd_dat),
    .rd_empty  (rd_empty),
    .underrun  (underrun),
    .wb        (wb)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  logic [31:0] seed;

  function automatic logic [31:0] memWord(input logic [23:0] a);
    return {~a[11:2], a[23:2]} ^ seed;
  endfunction

  assign wb.dat_i = memWord(wb.adr);

  int errors = 0;
  int checks = 0;

  // Reference model: expected bus cycle and FIFO contents.
  logic [31:0] m_q[$];
  logic [21:0] m_ptr;
  logic [23:0] m_adr;
  logic [2:0]  m_cti;
  logic        m_active;
  logic        m_under;
  logic        m_prev_en;
  int          m_beats;
  int          m_wait;

  logic rst_req;
  logic en_req;
  int   pop_pct;
  logic found;

  function automatic logic [21:0] nextPtr(input logic [21:0] p);
    return (p == end_adr) ? start_adr : p + 22'd1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    logic was_active;
    int   lvl_before;
    logic burst;
    @(posedge wb_clk);
    @(negedge wb_clk);
    if (wb_rst) begin
      m_q.delete();
      m_ptr     = start_adr;
      m_under   = 1'b0;
      m_active  = 1'b0;
      m_prev_en = 1'b0;
      m_adr     = '0;
      m_cti     = 3'b000;
    end else begin
      was_active = m_active;
      lvl_before = m_q.size();
      if (rd_en) begin
        if (lvl_before > 0) void'(m_q.pop_front());
        else m_under = 1'b1;
      end
      if (was_active && wb.ack) begin
        if (enable) m_q.push_back(memWord(m_adr));
        m_ptr = nextPtr(m_ptr);
        m_beats--;
        if (m_beats == 0) m_active = 1'b0;
        else begin
          m_adr = {m_ptr, 2'b00};
          m_cti = 3'b111;
        end
      end
      if (!was_active) begin
        if (!enable) m_q.delete();
        if (enable && !m_prev_en) begin
          m_ptr   = start_adr;
          m_under = 1'b0;
        end
        if (enable && (lvl_before <= DEPTH - 2)) begin
          burst    = !m_ptr[0] && (m_ptr != end_adr);
          m_active = 1'b1;
          m_beats  = burst ? 2 : 1;
          m_adr    = {m_ptr, 2'b00};
          m_cti    = burst ? 3'b010 : 3'b000;
          m_wait   = $urandom_range(3);
        end
      end
      m_prev_en = enable;
    end

    checkOutput("cyc", wb.cyc, m_active);
    checkOutput("stb", wb.stb, m_active);
    checkOutput("busy", busy, m_active);
    checkOutput("we", wb.we, 0);
    checkOutput("sel", wb.sel, 4'hF);
    if (m_active) begin
      checkOutput("adr", wb.adr, m_adr);
      checkOutput("cti", wb.cti, m_cti);
    end
    checkOutput("level", level, m_q.size());
    checkOutput("rd_empty", rd_empty, m_q.size() == 0);
    if (m_q.size() > 0) checkOutput("rd_dat", rd_dat, m_q[0]);
    checkOutput("underrun", underrun, m_under);

    rd_en = (en_req != enable || rst_req) ? 1'b0 : ($urandom_range(99) < pop_pct);
    if (m_active && !rst_req) begin
      if (m_wait == 0) begin
        wb.ack = 1'b1;
        m_wait = $urandom_range(3);
      end else begin
        wb.ack = 1'b0;
        m_wait--;
      end
    end else begin
      wb.ack = ($urandom_range(19) == 0);
    end
    enable = en_req;
    wb_rst = rst_req;
  endtask

  initial begin
    seed      = $urandom;
    wb_rst    = 1'b1;
    enable    = 1'b0;
    rd_en     = 1'b0;
    wb.ack    = 1'b0;
    start_adr = 22'h100;
    end_adr   = 22'h107;
    rst_req   = 1'b1;
    en_req    = 1'b0;
    pop_pct   = 0;
    m_active  = 1'b0;
    m_under   = 1'b0;
    m_prev_en = 1'b0;
    m_ptr     = '0;
    m_adr     = '0;
    m_cti     = '0;
    m_beats   = 0;
    m_wait    = 0;
    found     = 1'b0;

    repeat (3) applyStimulus();
    checkOutput("rst_cyc", wb.cyc, 0);
    checkOutput("rst_adr", wb.adr, 0);
    checkOutput("rst_cti", wb.cti, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_empty", rd_empty, 1);
    checkOutput("rst_underrun", underrun, 0);

    rst_req = 1'b0;
    repeat (2) applyStimulus();

    pop_pct = 100;
    applyStimulus();
    pop_pct = 0;
    applyStimulus();
    checkOutput("underrun_set", underrun, 1);
    checkOutput("underrun_level", level, 0);

    en_req = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("t1_adr", wb.adr, 24'h000400);
    checkOutput("t1_cti", wb.cti, 3'b010);
    checkOutput("t1_underrun_clr", underrun, 0);
    pop_pct = 30;
    repeat (300) applyStimulus();

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      applyStimulus();
      found = m_active && (m_cti == 3'b111) && !wb.ack;
    end
    checkOutput("t6_burst2_seen", found, 1);
    en_req = 1'b0;
    repeat (12) applyStimulus();
    checkOutput("t6_level", level, 0);
    checkOutput("t6_cyc", wb.cyc, 0);
    checkOutput("t6_busy", busy, 0);

    start_adr = 22'h101;
    end_adr   = 22'h107;
    pop_pct   = 0;
    en_req    = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("t2_adr", wb.adr, 24'h000404);
    checkOutput("t2_cti", wb.cti, 3'b000);
    repeat (150) applyStimulus();
    checkOutput("t4_fill_level", level, 15);
    checkOutput("t4_fill_cyc", wb.cyc, 0);
    pop_pct = 100;
    applyStimulus();
    pop_pct = 0;
    applyStimulus();
    checkOutput("t4_pop_level", level, 14);
    applyStimulus();
    checkOutput("t4_launch_cyc", wb.cyc, 1);
    checkOutput("t4_launch_adr", wb.adr, 24'h000408);
    checkOutput("t4_launch_cti", wb.cti, 3'b010);
    repeat (20) applyStimulus();

    en_req = 1'b0;
    repeat (8) applyStimulus();
    start_adr = 22'h100;
    end_adr   = 22'h102;
    en_req    = 1'b1;
    pop_pct   = 50;
    applyStimulus();
    applyStimulus();
    checkOutput("t3_adr", wb.adr, 24'h000400);
    checkOutput("t3_cti", wb.cti, 3'b010);
    repeat (300) applyStimulus();

    en_req = 1'b0;
    repeat (8) applyStimulus();
    start_adr = 22'h3FFFFD;
    end_adr   = 22'h000002;
    en_req    = 1'b1;
    pop_pct   = 40;
    repeat (300) applyStimulus();

    for (int r = 0; r < 4; r++) begin
      en_req = 1'b0;
      repeat (8) applyStimulus();
      start_adr = 22'($urandom);
      end_adr   = start_adr + 22'($urandom_range(24));
      pop_pct   = $urandom_range(10, 90);
      en_req    = 1'b1;
      repeat (250) applyStimulus();
    end

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      applyStimulus();
      found = m_active && !wb.ack;
    end
    checkOutput("t6r_req_seen", found, 1);
    rst_req = 1'b1;
    applyStimulus();
    rst_req = 1'b0;
    applyStimulus();
    checkOutput("t6r_cyc", wb.cyc, 0);
    checkOutput("t6r_stb", wb.stb, 0);
    checkOutput("t6r_level", level, 0);
    repeat (100) applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
